// File: rtl/alu_datapath.sv
// rtl/alu_datapath.sv - 8-bit accumulator ALU with registered result/flags and bus driver.
// Optional ALU_DC_EN builds the registered digit-carry flag; otherwise dc is tied to 0.
`timescale 1ns/1ps
module alu_datapath #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             exec_en,
   input  logic [3:0]       inst,
   input  logic [2:0]       bit_number,
   input  logic             switch_a_m,
   input  logic             dest,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] f,
   output logic [WIDTH-1:0] ans,
   output logic             carry,
   output logic             zero,
   output logic             dc,
   output logic             writeEn,
   output logic [WIDTH-1:0] data_bus,
   output logic             data_bus_oe
);

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_IOR  = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_COM  = 4'h5;
   localparam logic [3:0] OP_INC  = 4'h6;
   localparam logic [3:0] OP_DEC  = 4'h7;
   localparam logic [3:0] OP_MOVF = 4'h8;
   localparam logic [3:0] OP_MOVW = 4'h9;
   localparam logic [3:0] OP_RLF  = 4'hA;
   localparam logic [3:0] OP_RRF  = 4'hB;
   localparam logic [3:0] OP_SWAP = 4'hC;
   localparam logic [3:0] OP_BCF  = 4'hD;
   localparam logic [3:0] OP_BSF  = 4'hE;
   localparam logic [3:0] OP_CLR  = 4'hF;

   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] mask;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] r;
   logic             c_new;
   logic             z_upd;

   logic [WIDTH-1:0] ans_d, ans_q;
   logic             carry_d, carry_q;
   logic             zero_d, zero_q;
   logic             we_d, we_q;

   always_comb begin
      b       = switch_a_m ? k : f;
      mask    = '0;
      mask[bit_number] = 1'b1;
      sum     = {1'b0, a} + {1'b0, b};
      // Borrow appears in the extra MSB; C is its inverse (no-borrow).
      diff    = {1'b0, b} - {1'b0, a};
      r       = '0;
      c_new   = carry_q;
      z_upd   = 1'b1;
      case (inst)
         OP_ADD:  begin r = sum[WIDTH-1:0];  c_new = sum[WIDTH];   end
         OP_SUB:  begin r = diff[WIDTH-1:0]; c_new = ~diff[WIDTH]; end
         OP_AND:  r = a & b;
         OP_IOR:  r = a | b;
         OP_XOR:  r = a ^ b;
         OP_COM:  r = ~b;
         OP_INC:  r = b + 1'b1;
         OP_DEC:  r = b - 1'b1;
         OP_MOVF: r = b;
         OP_MOVW: r = a;
         OP_RLF:  begin r = {b[WIDTH-2:0], carry_q}; c_new = b[WIDTH-1]; z_upd = 1'b0; end
         OP_RRF:  begin r = {carry_q, b[WIDTH-1:1]}; c_new = b[0];       z_upd = 1'b0; end
         OP_SWAP: begin r = {b[3:0], b[WIDTH-1:4]}; z_upd = 1'b0; end
         OP_BCF:  begin r = b & ~mask; z_upd = 1'b0; end
         OP_BSF:  begin r = b | mask;  z_upd = 1'b0; end
         OP_CLR:  r = '0;
         default: r = '0;
      endcase

      ans_d   = ans_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      if (exec_en) begin
         ans_d   = r;
         carry_d = c_new;
         if (z_upd) zero_d = (r == '0);
      end
      we_d = exec_en & dest;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ans_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         ans_q   <= ans_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         we_q    <= we_d;
      end
   end

`ifdef ALU_DC_EN
   logic       dc_d, dc_q;
   logic [4:0] nib_sum;

   always_comb begin
      nib_sum = {1'b0, a[3:0]} + {1'b0, b[3:0]};
      dc_d    = dc_q;
      if (exec_en) begin
         if (inst == OP_ADD)      dc_d = nib_sum[4];
         else if (inst == OP_SUB) dc_d = (b[3:0] >= a[3:0]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) dc_q <= 1'b0;
      else        dc_q <= dc_d;
   end

   assign dc = dc_q;
`else
   assign dc = 1'b0;
`endif

   assign ans         = ans_q;
   assign carry       = carry_q;
   assign zero        = zero_q;
   assign writeEn     = we_q;
   assign data_bus_oe = we_q;
   assign data_bus    = we_q ? ans_q : '0;

endmodule

// File: tb/tb_alu_datapath.sv
// tb/tb_alu_datapath.sv - scoreboard bench for alu_datapath; honours ALU_DC_EN for dc expectations.
`timescale 1ns/1ps
module tb_alu_datapath;

   logic       clk = 1'b0;
   logic       reset;
   logic       exec_en;
   logic [3:0] inst;
   logic [2:0] bit_number;
   logic       switch_a_m;
   logic       dest;
   logic [7:0] a, k, f;
   logic [7:0] ans;
   logic       carry, zero, dc, writeEn, data_bus_oe;
   logic [7:0] data_bus;

`ifdef ALU_DC_EN
   localparam logic DC_ON = 1'b1;
`else
   localparam logic DC_ON = 1'b0;
`endif

   typedef struct {
      logic [7:0] ans;
      logic       c;
      logic       z;
      logic       dc;
      logic       we;
      logic [7:0] bus;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_fail = 0;
   logic tb_vld = 1'b0;
   logic fired  = 1'b0;

   always #5 clk = ~clk;

   alu_datapath #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .exec_en(exec_en), .inst(inst),
      .bit_number(bit_number), .switch_a_m(switch_a_m), .dest(dest),
      .a(a), .k(k), .f(f), .ans(ans), .carry(carry), .zero(zero), .dc(dc),
      .writeEn(writeEn), .data_bus(data_bus), .data_bus_oe(data_bus_oe)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ans"},  ans, 8'h00);
      chk({tag, "_c"},    {7'b0, carry}, 8'h00);
      chk({tag, "_z"},    {7'b0, zero}, 8'h00);
      chk({tag, "_dc"},   {7'b0, dc}, 8'h00);
      chk({tag, "_we"},   {7'b0, writeEn}, 8'h00);
      chk({tag, "_oe"},   {7'b0, data_bus_oe}, 8'h00);
      chk({tag, "_bus"},  data_bus, 8'h00);
   endtask

   // Marks the cycles whose result the monitor must check on the next falling edge.
   always @(posedge clk or negedge reset) begin
      if (!reset) fired <= 1'b0;
      else        fired <= tb_vld;
   end

   always @(negedge clk) begin
      if (fired) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_underflow: got empty queue expected an entry");
         end else begin
            mon_e = q.pop_front();
            chk("ans",         ans, mon_e.ans);
            chk("carry",       {7'b0, carry}, {7'b0, mon_e.c});
            chk("zero",        {7'b0, zero}, {7'b0, mon_e.z});
            chk("dc",          {7'b0, dc}, {7'b0, mon_e.dc});
            chk("writeEn",     {7'b0, writeEn}, {7'b0, mon_e.we});
            chk("data_bus_oe", {7'b0, data_bus_oe}, {7'b0, mon_e.we});
            chk("data_bus",    data_bus, mon_e.bus);
         end
      end
   end

   task automatic issue(input logic ex, input logic [3:0] op, input logic [2:0] bn,
                        input logic sam, input logic dst,
                        input logic [7:0] aa, input logic [7:0] kk, input logic [7:0] ff,
                        input logic [7:0] ea, input logic ec, input logic ez, input logic edc);
      exp_t e;
      @(negedge clk);
      exec_en    = ex;
      inst       = op;
      bit_number = bn;
      switch_a_m = sam;
      dest       = dst;
      a          = aa;
      k          = kk;
      f          = ff;
      tb_vld     = 1'b1;
      e.ans = ea;
      e.c   = ec;
      e.z   = ez;
      e.dc  = edc & DC_ON;
      e.we  = ex & dst;
      e.bus = (ex & dst) ? ea : 8'h00;
      q.push_back(e);
   endtask

   task automatic drain();
      @(negedge clk);
      tb_vld  = 1'b0;
      exec_en = 1'b0;
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      end
   endtask

   initial begin
      reset = 1'b0; exec_en = 1'b0; inst = 4'h0; bit_number = 3'd0;
      switch_a_m = 1'b0; dest = 1'b0; a = 8'h00; k = 8'h00; f = 8'h00;
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      reset = 1'b1;

      //     ex   op   bn  sam dst  a      k      f      ans    C  Z  dc
      issue(1, 4'h0, 0, 1, 0, 8'h25, 8'h10, 8'hAA, 8'h35, 0, 0, 0); // ADD literal
      issue(1, 4'h0, 0, 0, 1, 8'hF0, 8'h55, 8'h20, 8'h10, 1, 0, 0); // ADD file, carry
      issue(0, 4'h4, 0, 1, 1, 8'h12, 8'h34, 8'h56, 8'h10, 1, 0, 0); // idle holds
      issue(1, 4'h1, 0, 1, 0, 8'h05, 8'h05, 8'h00, 8'h00, 1, 1, 1); // SUB equal
      issue(1, 4'h1, 0, 1, 0, 8'h06, 8'h05, 8'h00, 8'hFF, 0, 0, 0); // SUB borrow
      issue(1, 4'h0, 0, 1, 0, 8'hFF, 8'h01, 8'h00, 8'h00, 1, 1, 1); // ADD wrap
      issue(1, 4'hA, 0, 0, 0, 8'h00, 8'h00, 8'h80, 8'h01, 1, 1, 1); // RLF C=1
      issue(1, 4'hB, 0, 0, 0, 8'h00, 8'h00, 8'h01, 8'h80, 1, 1, 1); // RRF C=1
      issue(1, 4'hE, 3, 0, 1, 8'h00, 8'h00, 8'h00, 8'h08, 1, 1, 1); // BSF bit3
      issue(1, 4'hD, 7, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h7F, 1, 1, 1); // BCF bit7
      issue(1, 4'hC, 5, 0, 0, 8'h00, 8'h00, 8'hA5, 8'h5A, 1, 1, 1); // SWAP
      issue(1, 4'hA, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 0, 1, 1); // RLF shifts C out
      issue(1, 4'hB, 0, 0, 0, 8'h00, 8'h00, 8'h02, 8'h01, 0, 1, 1); // RRF C=0
      issue(1, 4'h2, 0, 1, 0, 8'hF0, 8'h0F, 8'h00, 8'h00, 0, 1, 1); // AND
      issue(1, 4'h3, 0, 1, 0, 8'hF0, 8'h0F, 8'h00, 8'hFF, 0, 0, 1); // IOR
      issue(1, 4'h4, 0, 1, 0, 8'hFF, 8'h0F, 8'h00, 8'hF0, 0, 0, 1); // XOR
      issue(1, 4'h5, 0, 1, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 1, 1); // COM
      issue(1, 4'h6, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 1, 1); // INC wrap
      issue(1, 4'h7, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 0, 1); // DEC wrap
      issue(1, 4'h8, 0, 0, 0, 8'h00, 8'hEE, 8'h00, 8'h00, 0, 1, 1); // MOVF zero
      issue(1, 4'h9, 0, 0, 0, 8'h3C, 8'h00, 8'h00, 8'h3C, 0, 0, 1); // MOVW
      issue(1, 4'hF, 0, 0, 1, 8'h77, 8'h77, 8'h77, 8'h00, 0, 1, 1); // CLR to bus
      issue(1, 4'h0, 0, 1, 0, 8'h0F, 8'h01, 8'h00, 8'h10, 0, 0, 1); // ADD nibble carry
      drain();

      // Async reset in the middle of a cycle with an op pending on the inputs.
      @(negedge clk);
      exec_en = 1'b1; inst = 4'h9; a = 8'h77; dest = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(negedge clk);
      chk_all_zero("held_reset");
      exec_en = 1'b0;
      reset   = 1'b1;

      issue(1, 4'h0, 0, 1, 0, 8'h25, 8'h10, 8'h99, 8'h35, 0, 0, 0); // first op after release
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_datapath.md
Name: alu_datapath

Overview:
- 8-bit accumulator-style execution unit for the PIC-like core: operand select (literal/file), 16-op ALU, status flags, and a bus driver that returns results to the data bus.
- Sits between decode/W register/RAM.
- Single clock; results and flags are registered.

Parameters:
- WIDTH, 8, datapath width; the opcode table and bit_number width assume 8.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- exec_en  in  1  execute strobe; one operation per cycle when high.
- inst  in  4  ALU opcode.
- bit_number  in  3  bit index for BCF/BSF.
- switch_a_m  in  1  operand-b select: 1 = literal k, 0 = file data f.
- dest  in  1  1 = result goes to file/bus, 0 = result goes to W.
- a  in  8  W register value.
- k  in  8  literal from instruction register.
- f  in  8  file data from RAM.
- ans  out  8  registered ALU result.
- carry  out  1  registered carry/no-borrow flag.
- zero  out  1  registered zero flag.
- dc  out  1  digit carry; active only with ALU_DC_EN.
- writeEn  out  1  file write enable for the executed op.
- data_bus  out  8  bus value (result).
- data_bus_oe  out  1  bus drive enable; data_bus is 0 when low.

Behaviour:
- Reset (reset=0, asynchronous):
  - ans=0, carry=0, zero=0, dc=0, writeEn=0, data_bus_oe=0.
- Operand b (combinational): b = switch_a_m ? k : f.
- Opcode map (r = result):
  - 0 ADD: r = a + b, C = carry out of bit 7.
  - 1 SUB: r = b − a mod 256, C = 1 when b ≥ a (no borrow).
  - 2 AND: r = a & b.
  - 3 IOR: r = a | b.
  - 4 XOR: r = a ^ b.
  - 5 COM: r = ~b.
  - 6 INC: r = b + 1.
  - 7 DEC: r = b − 1 (both wrap mod 256).
  - 8 MOVF: r = b.
  - 9 MOVW: r = a.
  - A RLF: r = {b[6:0], C}, C = b[7].
  - B RRF: r = {C, b[7:1]}, C = b[0].
  - C SWAP: r = {b[3:0], b[7:4]}.
  - D BCF: r = b with bit bit_number cleared.
  - E BSF: r = b with bit bit_number set.
  - F CLR: r = 0.
- Flag update rules:
  - C updates only on ADD, SUB, RLF, RRF; otherwise it holds.
  - Z = (r == 0) updates on all ops except RLF, RRF, SWAP, BCF, BSF; otherwise it holds.
  - RLF/RRF use the registered carry value from before the edge.
- Latency and exec_en:
  - On a rising clk with exec_en=1: ans, flags, writeEn and data_bus_oe update together. Latency is 1 cycle.
  - With exec_en=0: ans and flags hold; writeEn=0, data_bus_oe=0.
- Write-back path:
  - writeEn = registered (exec_en & dest).
  - data_bus_oe = writeEn.
  - data_bus = data_bus_oe ? ans : 0.
- Back-to-back exec_en is allowed every cycle; each op sees the flags produced by the previous op.
- Reset asserted mid-operation: all outputs clear immediately; the first op after release executes normally.
- Unused bit_number is ignored for non-bit ops.

Optional Feature:
- ALU_DC_EN defined:
  - dc is registered on ADD as the carry out of bit 3.
  - dc is registered on SUB as the no-borrow from the low nibble (b[3:0] ≥ a[3:0]).
  - dc holds otherwise and resets to 0.
- ALU_DC_EN undefined: dc is constant 0 and no nibble logic is built.

Test Plan:
- Reset low mid-run -> all outputs 0 at once; after release, ADD a=0x25, k=0x10, switch_a_m=1, dest=0 -> next cycle ans=0x35, C=0, Z=0, writeEn=0, data_bus=0.
- ADD a=0xF0, f=0x20, switch_a_m=0, dest=1 -> ans=0x10, C=1, writeEn=1, data_bus_oe=1, data_bus=0x10.
- SUB a=5, k=5 -> ans=0, Z=1, C=1; then SUB a=6, k=5 -> ans=0xFF, C=0, Z=0.
- Set C=1 via ADD 0xFF+0x01, then RLF f=0x80 -> ans=0x01, C=1; RRF f=0x01 with C=1 -> ans=0x80, C=1.
- BSF f=0x00, bit_number=3 -> 0x08; BCF f=0xFF, bit_number=7 -> 0x7F; SWAP f=0xA5 -> 0x5A; flags unchanged.
- ALU_DC_EN defined: ADD a=0x0F, k=0x01 -> ans=0x10, dc=1, C=0. ALU_DC_EN undefined: same op gives dc=0.
